// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator control unit and its datapath:
// state codes, queue scan limit and the 2 s timer period at 1 kHz.
package elevador_pkg;

  typedef enum logic [3:0] {
    INICIAL         = 4'd0,
    OCIOSO          = 4'd1,
    REGISTRA        = 4'd2,
    BUSCA_ORIGEM    = 4'd3,
    INSERE_ORIGEM   = 4'd4,
    ESCREVE_ORIGEM  = 4'd5,
    PREP_DESTINO    = 4'd6,
    BUSCA_DESTINO   = 4'd7,
    INSERE_DESTINO  = 4'd8,
    ESCREVE_DESTINO = 4'd9,
    DESCARTA        = 4'd10,
    DECIDE          = 4'd11,
    DESLOCA         = 4'd12,
    PORTA           = 4'd13
  } estado_t;

  localparam int unsigned SCAN_MAX      = 15;
  localparam int unsigned TIMER_PERIODO = 2000;

endpackage

// File: rtl/uc_elevador.sv
// Elevator control unit: schedules origin/destination stops into the queue RAM
// and drives the car floor by floor, opening the door at each stop.
module uc_elevador #(
  parameter int unsigned SCAN_MAX = elevador_pkg::SCAN_MAX
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_bordaNovaEntrada,
  input  logic       i_fimT,
  input  logic       i_chegouDestino,
  input  logic       i_temDestino,
  input  logic       i_sobe,
  input  logic       i_carona_origem,
  input  logic       i_carona_destino,
  input  logic       i_ramSecDifZero,
  output logic       o_shift,
  output logic       o_enableRAM,
  output logic       o_enableTopRAM,
  output logic       o_fit,
  output logic       o_select1,
  output logic       o_select2,
  output logic       o_select3,
  output logic       o_zeraT,
  output logic       o_contaT,
  output logic       o_clearAndarAtual,
  output logic       o_clearSuperRam,
  output logic       o_enableAndarAtual,
  output logic       o_enableRegOrigem,
  output logic       o_enableRegDestino,
  output logic       o_enableRegCaronaOrigem,
  output logic       o_zeraAddrSecundario,
  output logic       o_contaAddrSecundario,
  output logic       o_porta_aberta,
  output logic       o_erro,
  output logic [3:0] o_db_estado
);
  import elevador_pkg::*;

  localparam logic [3:0] SCAN_LAST = 4'(SCAN_MAX);

  estado_t    r_state;
  logic [3:0] r_scan;
  logic       r_pendente;

  estado_t    w_state;
  estado_t    w_next;
  logic [3:0] w_scan_next;
  logic       w_scan_last;

  // While reset is held the outputs already show INICIAL, so an abandoned
  // search cannot issue a RAM write in the reset cycle.
  assign w_state     = i_reset ? r_state : INICIAL;
  assign w_scan_last = (r_scan == SCAN_LAST);
  assign o_db_estado = w_state;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= INICIAL;
      r_scan     <= 4'd0;
      r_pendente <= 1'b0;
    end else begin
      r_state <= w_next;
      r_scan  <= w_scan_next;
      if (r_state == REGISTRA)
        r_pendente <= 1'b0;
      else if (i_bordaNovaEntrada && (r_state != OCIOSO))
        r_pendente <= 1'b1;
    end
  end

  always_comb begin
    w_next                  = INICIAL;
    w_scan_next             = r_scan;
    o_shift                 = 1'b0;
    o_enableRAM             = 1'b0;
    o_enableTopRAM          = 1'b0;
    o_fit                   = 1'b0;
    o_select1               = 1'b0;
    o_select2               = 1'b0;
    o_select3               = 1'b0;
    o_zeraT                 = 1'b0;
    o_contaT                = 1'b0;
    o_clearAndarAtual       = 1'b0;
    o_clearSuperRam         = 1'b0;
    o_enableAndarAtual      = 1'b0;
    o_enableRegOrigem       = 1'b0;
    o_enableRegDestino      = 1'b0;
    o_enableRegCaronaOrigem = 1'b0;
    o_zeraAddrSecundario    = 1'b0;
    o_contaAddrSecundario   = 1'b0;
    o_porta_aberta          = 1'b0;
    o_erro                  = 1'b0;

    case (w_state)
      INICIAL: begin
        o_zeraT              = 1'b1;
        o_zeraAddrSecundario = 1'b1;
        o_clearAndarAtual    = 1'b1;
        o_clearSuperRam      = 1'b1;
        w_next               = OCIOSO;
      end
      OCIOSO: begin
        if (i_bordaNovaEntrada || r_pendente) w_next = REGISTRA;
        else if (i_temDestino)                w_next = DECIDE;
        else                                  w_next = OCIOSO;
      end
      REGISTRA: begin
        o_enableRegOrigem    = 1'b1;
        o_enableRegDestino   = 1'b1;
        o_zeraAddrSecundario = 1'b1;
        w_scan_next          = 4'd0;
        w_next               = BUSCA_ORIGEM;
      end
      BUSCA_ORIGEM: begin
        o_select1 = 1'b1;
        o_select3 = (r_scan == 4'd0);
        if (i_carona_origem)       w_next = INSERE_ORIGEM;
        else if (!i_ramSecDifZero) w_next = ESCREVE_ORIGEM;
        else if (w_scan_last)      w_next = DESCARTA;
        else begin
          o_contaAddrSecundario = 1'b1;
          w_scan_next           = r_scan + 4'd1;
          w_next                = BUSCA_ORIGEM;
        end
      end
      INSERE_ORIGEM: begin
        o_fit                   = 1'b1;
        o_select1               = 1'b1;
        o_enableRegCaronaOrigem = 1'b1;
        w_next                  = PREP_DESTINO;
      end
      ESCREVE_ORIGEM: begin
        o_enableRAM             = 1'b1;
        o_select1               = 1'b1;
        o_enableRegCaronaOrigem = 1'b1;
        w_next                  = PREP_DESTINO;
      end
      PREP_DESTINO: begin
        // The destination must land after the origin, so it starts one slot on.
        if (w_scan_last) w_next = DESCARTA;
        else begin
          o_contaAddrSecundario = 1'b1;
          w_scan_next           = r_scan + 4'd1;
          w_next                = BUSCA_DESTINO;
        end
      end
      BUSCA_DESTINO: begin
        if (i_carona_destino)      w_next = INSERE_DESTINO;
        else if (!i_ramSecDifZero) w_next = ESCREVE_DESTINO;
        else if (w_scan_last)      w_next = DESCARTA;
        else begin
          o_contaAddrSecundario = 1'b1;
          w_scan_next           = r_scan + 4'd1;
          w_next                = BUSCA_DESTINO;
        end
      end
      INSERE_DESTINO: begin
        o_fit                = 1'b1;
        o_zeraAddrSecundario = 1'b1;
        w_next               = OCIOSO;
      end
      ESCREVE_DESTINO: begin
        o_enableRAM          = 1'b1;
        o_zeraAddrSecundario = 1'b1;
        w_next               = OCIOSO;
      end
      DESCARTA: begin
        o_erro               = 1'b1;
        o_zeraAddrSecundario = 1'b1;
        w_next               = OCIOSO;
      end
      DECIDE: begin
        o_zeraT = 1'b1;
        if (r_pendente)           w_next = REGISTRA;
        else if (!i_temDestino)   w_next = OCIOSO;
        else if (i_chegouDestino) w_next = PORTA;
        else                      w_next = DESLOCA;
      end
      DESLOCA: begin
        o_contaT = 1'b1;
        w_next   = DESLOCA;
        if (i_fimT) begin
          o_enableAndarAtual = 1'b1;
          o_select2          = i_sobe;
          o_zeraT            = 1'b1;
          w_next             = DECIDE;
        end
      end
      PORTA: begin
        o_porta_aberta = 1'b1;
        o_contaT       = 1'b1;
        w_next         = PORTA;
        if (i_fimT) begin
          o_shift = 1'b1;
          o_zeraT = 1'b1;
          w_next  = DECIDE;
        end
      end
      default: w_next = INICIAL;
    endcase
  end

endmodule

// File: tb/tb_uc_elevador.sv
// Directed bench for uc_elevador: the datapath status inputs are driven by hand
// and every control output is compared against hand-derived values.
module tb_uc_elevador;

  logic       clock = 1'b0;
  logic       reset;
  logic       borda, fimT, chegou, temDest, sobe, c_orig, c_dest, ramDif;
  logic       shift, enRAM, enTop, fit, sel1, sel2, sel3, zeraT, contaT;
  logic       clrAndar, clrRam, enAndar, enRegO, enRegD, enRegC, zeraAddr, contaAddr;
  logic       porta, erro;
  logic [3:0] db;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  uc_elevador dut (
    .i_clock(clock), .i_reset(reset), .i_bordaNovaEntrada(borda), .i_fimT(fimT),
    .i_chegouDestino(chegou), .i_temDestino(temDest), .i_sobe(sobe),
    .i_carona_origem(c_orig), .i_carona_destino(c_dest), .i_ramSecDifZero(ramDif),
    .o_shift(shift), .o_enableRAM(enRAM), .o_enableTopRAM(enTop), .o_fit(fit),
    .o_select1(sel1), .o_select2(sel2), .o_select3(sel3), .o_zeraT(zeraT),
    .o_contaT(contaT), .o_clearAndarAtual(clrAndar), .o_clearSuperRam(clrRam),
    .o_enableAndarAtual(enAndar), .o_enableRegOrigem(enRegO),
    .o_enableRegDestino(enRegD), .o_enableRegCaronaOrigem(enRegC),
    .o_zeraAddrSecundario(zeraAddr), .o_contaAddrSecundario(contaAddr),
    .o_porta_aberta(porta), .o_erro(erro), .o_db_estado(db)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Enters DESLOCA from DECIDE, lets the timer run, then fires fimT; ends in DECIDE.
  task automatic floor_step(input logic dir);
    tick;
    sobe = dir; fimT = 1'b0;
    #1;
    chk4("desloca_state", db, 4'd12);
    chk1("desloca_contaT", contaT, 1'b1);
    chk1("desloca_noadvance", enAndar, 1'b0);
    repeat (3) tick;
    fimT = 1'b1;
    #1;
    chk1("floor_enAndar", enAndar, 1'b1);
    chk1("floor_select2", sel2, dir);
    chk1("floor_zeraT", zeraT, 1'b1);
    tick;
    fimT = 1'b0;
    #1;
    chk4("decide_state", db, 4'd11);
  endtask

  // Enters PORTA from DECIDE (chegouDestino high); ends in DECIDE after the pop.
  task automatic door_stop;
    chegou = 1'b1;
    tick;
    chegou = 1'b0;
    #1;
    chk4("porta_state", db, 4'd13);
    chk1("porta_aberta", porta, 1'b1);
    chk1("porta_noshift", shift, 1'b0);
    repeat (2) tick;
    fimT = 1'b1;
    #1;
    chk1("porta_shift", shift, 1'b1);
    chk1("porta_zeraT", zeraT, 1'b1);
    tick;
    fimT = 1'b0;
    #1;
    chk4("after_door_state", db, 4'd11);
  endtask

  initial begin
    int pulses;
    int errs;
    int bad;

    reset = 1'b0; borda = 1'b0; fimT = 1'b0; chegou = 1'b0; temDest = 1'b0;
    sobe = 1'b0; c_orig = 1'b0; c_dest = 1'b0; ramDif = 1'b0;

    // Reset held for two edges
    tick; tick;
    chk4("rst_db", db, 4'd0);
    chk1("rst_zeraT", zeraT, 1'b1);
    chk1("rst_zeraAddr", zeraAddr, 1'b1);
    chk1("rst_clrAndar", clrAndar, 1'b1);
    chk1("rst_clrRam", clrRam, 1'b1);
    chk1("rst_enRAM", enRAM, 1'b0);
    chk1("rst_erro", erro, 1'b0);
    reset = 1'b1;
    tick;
    chk4("release_db", db, 4'd1);

    // Request 3 -> 5 on an empty queue
    borda = 1'b1;
    tick;
    borda = 1'b0;
    #1;
    chk4("reg_db", db, 4'd2);
    chk1("reg_enRegO", enRegO, 1'b1);
    chk1("reg_enRegD", enRegD, 1'b1);
    chk1("reg_zeraAddr", zeraAddr, 1'b1);
    tick;
    ramDif = 1'b0;
    #1;
    chk4("buscaO_db", db, 4'd3);
    chk1("buscaO_sel1", sel1, 1'b1);
    chk1("buscaO_sel3_scan0", sel3, 1'b1);
    chk1("buscaO_noconta", contaAddr, 1'b0);
    tick;
    chk4("escO_db", db, 4'd5);
    chk1("escO_enRAM", enRAM, 1'b1);
    chk1("escO_enRegC", enRegC, 1'b1);
    chk1("escO_fit", fit, 1'b0);
    tick;
    chk4("prep_db", db, 4'd6);
    chk1("prep_conta", contaAddr, 1'b1);
    tick;
    chk4("buscaD_db", db, 4'd7);
    chk1("buscaD_sel1", sel1, 1'b0);
    chk1("buscaD_sel3", sel3, 1'b0);
    tick;
    chk4("escD_db", db, 4'd9);
    chk1("escD_enRAM", enRAM, 1'b1);
    chk1("escD_zeraAddr", zeraAddr, 1'b1);
    tick;
    temDest = 1'b1;
    #1;
    chk4("idle_after_req", db, 4'd1);
    tick;
    chk4("decide_db", db, 4'd11);
    chk1("decide_zeraT", zeraT, 1'b1);
    for (int f = 0; f < 3; f++) floor_step(1'b1);
    door_stop();
    for (int f = 0; f < 2; f++) floor_step(1'b1);
    door_stop();
    temDest = 1'b0;
    tick;
    chk4("trip_done_idle", db, 4'd1);

    // Carona: origin rides at slot 1, destination at slot 2
    borda = 1'b1;
    tick;
    borda = 1'b0;
    tick;
    ramDif = 1'b1; c_orig = 1'b0;
    #1;
    chk1("car_scan0_conta", contaAddr, 1'b1);
    chk1("car_scan0_sel3", sel3, 1'b1);
    tick;
    c_orig = 1'b1;
    #1;
    chk1("car_scan1_sel3", sel3, 1'b0);
    chk1("car_scan1_noconta", contaAddr, 1'b0);
    tick;
    c_orig = 1'b0;
    #1;
    chk4("insO_db", db, 4'd4);
    chk1("insO_fit", fit, 1'b1);
    chk1("insO_enRegC", enRegC, 1'b1);
    chk1("insO_enRAM", enRAM, 1'b0);
    tick;
    tick;
    c_dest = 1'b1;
    #1;
    chk4("car_buscaD_db", db, 4'd7);
    chk1("car_buscaD_noconta", contaAddr, 1'b0);
    tick;
    c_dest = 1'b0;
    #1;
    chk4("insD_db", db, 4'd8);
    chk1("insD_fit", fit, 1'b1);
    chk1("insD_zeraAddr", zeraAddr, 1'b1);
    tick;
    ramDif = 1'b0;
    #1;
    chk4("car_done_idle", db, 4'd1);

    // Full queue: request dropped after scanning every slot
    borda = 1'b1;
    tick;
    borda = 1'b0;
    tick;
    ramDif = 1'b1;
    pulses = 0; errs = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (contaAddr) pulses++;
      if (erro) errs++;
      if (db == 4'd1 && errs > 0) break;
      tick;
    end
    chkn("full_conta_pulses", pulses, 15);
    chkn("full_erro_cycles", errs, 1);
    chk4("full_back_idle", db, 4'd1);
    ramDif = 1'b0;

    // Origin lands in the last slot: no room left for the destination
    borda = 1'b1;
    tick;
    borda = 1'b0;
    tick;
    ramDif = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (contaAddr) pulses++;
      if (pulses == 15) break;
      tick;
    end
    tick;
    ramDif = 1'b0;
    #1;
    chk4("last_slot_db", db, 4'd3);
    chk1("last_slot_noconta", contaAddr, 1'b0);
    tick;
    chk1("last_slot_enRAM", enRAM, 1'b1);
    tick;
    chk4("last_prep_db", db, 4'd6);
    chk1("last_prep_noconta", contaAddr, 1'b0);
    tick;
    chk1("last_descarta_erro", erro, 1'b1);
    chk1("last_descarta_zera", zeraAddr, 1'b1);
    tick;
    chk4("last_idle", db, 4'd1);
    chk1("last_erro_gone", erro, 1'b0);

    // New request arriving together with fimT while travelling down
    temDest = 1'b1;
    tick;
    chegou = 1'b0;
    tick;
    sobe = 1'b0; fimT = 1'b1; borda = 1'b1;
    #1;
    chk4("pend_desloca_db", db, 4'd12);
    chk1("pend_enAndar", enAndar, 1'b1);
    chk1("pend_select2_down", sel2, 1'b0);
    tick;
    fimT = 1'b0; borda = 1'b0;
    #1;
    chk4("pend_decide_db", db, 4'd11);
    tick;
    chk4("pend_registra_db", db, 4'd2);

    // Reset while searching for the destination slot
    tick;
    ramDif = 1'b1;
    tick;
    ramDif = 1'b0;
    tick; tick; tick;
    chk4("pre_rst_buscaD", db, 4'd7);
    borda = 1'b1; reset = 1'b0;
    #1;
    chk4("midrst_db", db, 4'd0);
    chk1("midrst_enRAM", enRAM, 1'b0);
    chk1("midrst_clrRam", clrRam, 1'b1);
    tick;
    borda = 1'b0;
    tick;
    reset = 1'b1; temDest = 1'b0;
    tick;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (db != 4'd1 || enRAM || fit) bad++;
      tick;
    end
    chkn("post_rst_idle_cycles_bad", bad, 0);
    chk1("enableTopRAM_low", enTop, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
